// File: rtl/tdm_demux1to4.sv
// Receive-side TDM demultiplexer: recovers four channels from a slot-interleaved
// stream, acquires and tracks frame alignment, and publishes one full frame at a time.
module tdm_demux1to4 #(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     y_in,
    input  logic                 en,
    input  logic                 fsync,
    output logic [4*WIDTH-1:0]   w_out,
    output logic [1:0]           s_cur,
    output logic                 frame_valid,
    output logic                 locked
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [2:0] MISS_LIM = 3'(MISS_LIMIT);

    state_e              state_q;
    logic [1:0]          slot_q;
    logic [1:0]          slot_d;
    logic [2:0]          miss_q;
    logic [2:0]          miss_d;
    logic [WIDTH-1:0]    sh0_q;
    logic [WIDTH-1:0]    sh1_q;
    logic [WIDTH-1:0]    sh2_q;
    logic [4*WIDTH-1:0]  w_q;
    logic                fv_q;
    logic                locked_q;

    logic                slot0;
    logic                miss_evt;
    logic                miss_hit;

    assign slot_d   = slot_q + 2'd1;
    assign miss_d   = miss_q + 3'd1;
    assign slot0    = (slot_q == 2'd0);
    // A sync check fails when fsync is absent at slot 0 or present anywhere else.
    assign miss_evt = slot0 ? !fsync : fsync;
    assign miss_hit = miss_evt && (miss_d >= MISS_LIM);

    // NOTE: every register in this block uses non-blocking assignment so all
    // branches read the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            slot_q   <= 2'd0;
            miss_q   <= 3'd0;
            sh0_q    <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            w_q      <= '0;
            fv_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_HUNT: begin
                        if (fsync) begin
                            sh0_q   <= y_in;
                            slot_q  <= 2'd1;
                            state_q <= ST_VERIFY;
                        end
                    end

                    ST_VERIFY: begin
                        if (fsync) begin
                            // Either the confirming sync at slot 0 or a realignment mid-frame.
                            sh0_q  <= y_in;
                            slot_q <= 2'd1;
                            if (slot0) begin
                                miss_q   <= 3'd0;
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (slot0) begin
                            slot_q  <= 2'd0;
                            state_q <= ST_HUNT;
                        end else begin
                            case (slot_q)
                                2'd1:    sh1_q <= y_in;
                                2'd2:    sh2_q <= y_in;
                                default: ;
                            endcase
                            slot_q <= slot_d;
                        end
                    end

                    ST_LOCKED: begin
                        // The slot-3 publish happens even if this same sample drops lock.
                        if (slot_q == 2'd3) begin
                            w_q  <= {y_in, sh2_q, sh1_q, sh0_q};
                            fv_q <= 1'b1;
                        end
                        if (miss_hit) begin
                            slot_q   <= 2'd0;
                            miss_q   <= 3'd0;
                            state_q  <= ST_HUNT;
                            locked_q <= 1'b0;
                        end else begin
                            case (slot_q)
                                2'd0:    sh0_q <= y_in;
                                2'd1:    sh1_q <= y_in;
                                2'd2:    sh2_q <= y_in;
                                default: ;
                            endcase
                            slot_q <= slot_d;
                            if (miss_evt) begin
                                miss_q <= miss_d;
                            end else if (slot0) begin
                                miss_q <= 3'd0;
                            end
                        end
                    end

                    default: begin
                        slot_q   <= 2'd0;
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_out       = w_q;
    assign s_cur       = slot_q;
    assign frame_valid = fv_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux1to4.sv
// Directed bench for tdm_demux1to4: a behavioural model plus a frame scoreboard
// checked on every clock, with targeted checks at the interesting edges.
module tb_tdm_demux1to4;

    localparam int W  = 4;
    localparam int ML = 2;

    typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mstate_e;

    logic             clk;
    logic             rst;
    logic [W-1:0]     y_in;
    logic             en;
    logic             fsync;
    logic [4*W-1:0]   w_out;
    logic [1:0]       s_cur;
    logic             frame_valid;
    logic             locked;

    int n_checks = 0;
    int n_pass   = 0;

    mstate_e          m_st;
    int               m_slot;
    int               m_miss;
    logic [W-1:0]     m_sh[4];
    logic [4*W-1:0]   m_w;
    logic             m_fv;
    logic             m_locked;
    logic [4*W-1:0]   sb[$];

    logic [W-1:0]     d2[4] = '{4'h1, 4'h0, 4'h1, 4'h1};
    logic [W-1:0]     d5[4] = '{4'h3, 4'hA, 4'h5, 4'hC};

    tdm_demux1to4 #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .y_in        (y_in),
        .en          (en),
        .fsync       (fsync),
        .w_out       (w_out),
        .s_cur       (s_cur),
        .frame_valid (frame_valid),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Expected behaviour for one clock edge, written from the block description.
    task automatic model_edge(input logic r, input logic e, input logic f, input logic [W-1:0] y);
        logic bad;
        m_fv = 1'b0;
        if (r) begin
            m_st = M_HUNT; m_slot = 0; m_miss = 0; m_w = '0;
            for (int k = 0; k < 4; k++) m_sh[k] = '0;
        end else if (e) begin
            case (m_st)
                M_HUNT: begin
                    if (f) begin m_sh[0] = y; m_slot = 1; m_st = M_VERIFY; end
                end
                M_VERIFY: begin
                    if (m_slot == 0) begin
                        if (f) begin m_sh[0] = y; m_slot = 1; m_miss = 0; m_st = M_LOCKED; end
                        else begin m_slot = 0; m_st = M_HUNT; end
                    end else if (f) begin
                        m_sh[0] = y; m_slot = 1;
                    end else begin
                        m_sh[m_slot] = y; m_slot = (m_slot + 1) % 4;
                    end
                end
                default: begin
                    bad = (m_slot == 0 && !f) || (m_slot != 0 && f);
                    if (m_slot == 3) begin
                        m_w = {y, m_sh[2], m_sh[1], m_sh[0]};
                        m_fv = 1'b1;
                        sb.push_back(m_w);
                    end
                    if (m_slot == 0 && f) m_miss = 0;
                    if (bad) m_miss++;
                    if (bad && m_miss >= ML) begin
                        m_slot = 0; m_miss = 0; m_st = M_HUNT;
                    end else begin
                        m_sh[m_slot] = y; m_slot = (m_slot + 1) % 4;
                    end
                end
            endcase
        end
        m_locked = (m_st == M_LOCKED);
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic [W-1:0] y);
        @(negedge clk);
        rst = r; en = e; fsync = f; y_in = y;
        model_edge(r, e, f, y);
        @(posedge clk);
        #1;
        check("s_cur", s_cur, m_slot);
        check("locked", locked, m_locked);
        check("frame_valid", frame_valid, m_fv);
        check("w_out", w_out, m_w);
        if (frame_valid === 1'b1) begin
            if (sb.size() == 0) check("sb_unexpected_frame", frame_valid, 1'b0);
            else check("sb_frame", w_out, sb.pop_front());
        end
    endtask

    task automatic frame2(input logic sync0, input logic sync2);
        for (int s = 0; s < 4; s++)
            step(1'b0, 1'b1, (s == 0) ? sync0 : ((s == 2) ? sync2 : 1'b0), d2[s]);
    endtask

    task automatic frame5(input logic sync0);
        for (int s = 0; s < 4; s++)
            step(1'b0, 1'b1, (s == 0) ? sync0 : 1'b0, d5[s]);
    endtask

    initial begin
        int first_fv;
        int prev_fv;

        rst = 1'b1; en = 1'b0; fsync = 1'b0; y_in = '0;
        m_st = M_HUNT; m_slot = 0; m_miss = 0; m_w = '0; m_fv = 1'b0; m_locked = 1'b0;
        for (int k = 0; k < 4; k++) m_sh[k] = '0;

        // Reset with random stimulus on the other inputs.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), W'($urandom_range(15)));
        check("rst_w", w_out, 16'h0000);
        check("rst_locked", locked, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Acquisition, en every cycle.
        first_fv = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, (i % 4) == 0, d2[i % 4]);
            if (i == 3) check("acq_unlocked_c3", locked, 1'b0);
            if (i == 4) check("acq_locked_c4", locked, 1'b1);
            if (frame_valid === 1'b1 && first_fv < 0) first_fv = i;
        end
        check("acq_first_fv", first_fv, 7);
        check("acq_w", w_out, 16'h1101);

        // Same stream with en on alternate cycles.
        step(1'b1, 1'b0, 1'b0, '0);
        first_fv = -1;
        prev_fv  = -1;
        for (int i = 0; i < 48; i++) begin
            step(1'b0, (i % 2) == 0, ((i / 2) % 4) == 0, d2[(i / 2) % 4]);
            if (frame_valid === 1'b1) begin
                if (first_fv < 0) first_fv = i;
                else check("gap_period", i - prev_fv, 8);
                prev_fv = i;
            end
        end
        check("gap_first_fv", first_fv, 14);
        check("gap_w", w_out, 16'h1101);

        // Miss tolerance while locked.
        frame2(1'b0, 1'b0);
        check("miss1_locked", locked, 1'b1);
        frame2(1'b1, 1'b0);
        frame2(1'b1, 1'b1);
        check("stray_sync_locked", locked, 1'b1);
        frame2(1'b1, 1'b0);
        frame2(1'b0, 1'b0);
        check("miss_once_locked", locked, 1'b1);
        step(1'b0, 1'b1, 1'b0, d2[0]);
        check("miss2_drop", locked, 1'b0);
        for (int s = 1; s < 4; s++) step(1'b0, 1'b1, 1'b0, d2[s]);
        check("miss2_no_frame", frame_valid, 1'b0);
        frame2(1'b1, 1'b0);
        check("reacq_first_sync", locked, 1'b0);
        step(1'b0, 1'b1, 1'b1, d2[0]);
        check("reacq_second_sync", locked, 1'b1);
        for (int s = 1; s < 4; s++) step(1'b0, 1'b1, 1'b0, d2[s]);

        // Realignment while verifying.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 4'h7);
        step(1'b0, 1'b1, 1'b0, 4'h8);
        step(1'b0, 1'b1, 1'b1, 4'h3);
        check("realign_s_cur", s_cur, 2'd1);
        for (int s = 1; s < 4; s++) step(1'b0, 1'b1, 1'b0, d5[s]);
        check("realign_not_locked", locked, 1'b0);
        frame5(1'b1);
        check("realign_w", w_out, 16'hC5A3);
        check("realign_locked", locked, 1'b1);

        // Realignment not confirmed: no sync at the new slot 0.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 4'h7);
        step(1'b0, 1'b1, 1'b0, 4'h8);
        step(1'b0, 1'b1, 1'b1, 4'h3);
        for (int s = 1; s < 4; s++) step(1'b0, 1'b1, 1'b0, d5[s]);
        step(1'b0, 1'b1, 1'b0, 4'h3);
        check("unconfirmed_locked", locked, 1'b0);
        check("unconfirmed_s_cur", s_cur, 2'd0);

        // Lock up again, then reset mid-frame.
        frame5(1'b1);
        frame5(1'b1);
        check("relock_w", w_out, 16'hC5A3);
        step(1'b0, 1'b1, 1'b1, d5[0]);
        step(1'b0, 1'b1, 1'b0, d5[1]);
        check("mid_s_cur", s_cur, 2'd2);
        check("mid_locked", locked, 1'b1);
        step(1'b1, 1'b1, 1'b0, d5[2]);
        check("midrst_locked", locked, 1'b0);
        check("midrst_w", w_out, 16'h0000);
        check("midrst_s_cur", s_cur, 2'd0);
        check("midrst_fv", frame_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0, d5[2]);
        step(1'b0, 1'b1, 1'b0, d5[3]);
        check("resume_hunt_fv", frame_valid, 1'b0);
        frame5(1'b1);
        check("resume_verify", locked, 1'b0);
        frame5(1'b1);
        check("resume_locked", locked, 1'b1);
        check("resume_w", w_out, 16'hC5A3);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux1to4.md
Name: tdm_demux1to4

Overview:
- Receive-side partner of the 4-to-1 selector datapath.
- Takes a time-division-multiplexed sample stream (slot 0,1,2,3 repeating, slot 0 flagged by a frame-sync strobe) and recovers the four channels w0..w3.
- Acquires and tracks frame alignment with a small lock state machine, publishes all four channels together once per frame, and drops lock after repeated sync misses.

Parameters:
WIDTH, 1, bits per channel sample
MISS_LIMIT, 2, consecutive bad slot-0 sync checks before lock is dropped (legal range 1..7)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous active-high reset
y_in  input  WIDTH  multiplexed sample
en  input  1  sample strobe; y_in/fsync are consumed only on edges with en=1
fsync  input  1  frame sync, qualified by en; marks the slot-0 sample
w_out  output  4*WIDTH  recovered channels; channel i at bits [i*WIDTH +: WIDTH]
s_cur  output  2  slot index the next accepted sample will fill
frame_valid  output  1  one-cycle pulse: w_out updated this cycle
locked  output  1  high while in LOCKED

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - state=HUNT; slot counter, shadow registers, miss counter = 0.
  - w_out=0, s_cur=0, frame_valid=0, locked=0.
- Accepted sample = edge with en=1. With en=0, no state changes and frame_valid=0.
- All outputs are registered; s_cur mirrors the slot counter.
- Slot counter is 2 bits and wraps 3 -> 0. The shadow register for the current slot is loaded with y_in on each accepted sample in VERIFY and LOCKED.
- HUNT:
  - Accepted samples are ignored, counter held at 0.
  - Accepted sample with fsync=1: shadow[0]<=y_in, counter<=1, go VERIFY.
- VERIFY:
  - Accepted sample with counter=0 and fsync=1: capture as slot 0, counter<=1, miss<=0, go LOCKED.
  - Accepted sample with counter=0 and fsync=0: go HUNT, counter<=0.
  - fsync=1 at counter 1..3: realign, meaning capture as slot 0, counter<=1, stay VERIFY.
  - Frames completed in VERIFY are never published.
- LOCKED:
  - Every accepted slot-3 sample: w_out <= {y_in, shadow[2], shadow[1], shadow[0]}, frame_valid=1 for exactly the following cycle. Latency is one edge from slot-3 acceptance.
  - Slot-0 check, taken on an accepted sample with counter=0:
    - fsync=1 -> miss<=0.
    - fsync=0 -> miss<=miss+1.
  - If the incremented miss reaches MISS_LIMIT: go HUNT, locked<=0, counter<=0, sample discarded. Otherwise capture normally.
  - fsync=1 at counter 1..3 counts as a miss by the same rule. No realignment occurs while LOCKED; the sample is still captured in its counted slot.
  - If a miss-limit hit and a slot-3 publish would fall on the same sample, the publish still occurs.
- locked<=1 on the VERIFY->LOCKED edge and <=0 on any exit from LOCKED. w_out holds its last published value after lock loss until the next publish or reset.
- Reset mid-frame discards the partial frame; no frame_valid is produced for it.

Test Plan:
1. Reset: rst=1 for 2 cycles with random y_in/fsync/en toggling -> w_out=0, s_cur=0, frame_valid=0, locked=0 on the cycle after the first reset edge.
2. Acquisition:
   - Setup: WIDTH=1, en=1 every cycle, repeating slots 0..3 = 1,0,1,1, fsync high on slot 0, first fsync at cycle 0.
   - locked=1 after the cycle-4 edge.
   - First frame_valid follows the cycle-7 edge with w_out=4'b1101, then repeats every 4 cycles.
   - No frame_valid before cycle 7.
3. Strobe gaps: same stream as scenario 2 with en high on alternate cycles (data held across gaps) -> identical w_out=4'b1101, frame_valid period 8 cycles, s_cur frozen during en=0.
4. Miss tolerance (MISS_LIMIT=2, locked):
   - Drop fsync on one frame -> locked stays 1, frames still published.
   - Drop fsync on two consecutive frames -> locked falls after the second missing slot-0 edge, no further frame_valid.
   - Restoring fsync reacquires: locked=1 after the second good sync.
5. Realign in VERIFY: after the first fsync, assert fsync again at slot 2 -> s_cur becomes 1 on that edge. Lock is then declared 4 accepted samples later only if fsync is present there, and the published frame uses the new alignment (WIDTH=4, slots 0x3,0xA,0x5,0xC -> w_out=16'hC5A3).
6. Reset mid-operation: while locked at s_cur=2, pulse rst one cycle -> next cycle locked=0, w_out=0, s_cur=0, no frame_valid. Resuming the stream requires full reacquisition as in scenario 2.
